dmem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_unit.sv | 67 ++++++
 rtl/dmem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: FSM states, access sizes and requester ids.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: alignment check, load extraction with sign/zero extension,
// and byte-lane merge of a sub-doubleword store into the word read from memory.
import dmem_pkg::*;

module dmem_lane_unit (
  input  logic [2:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic        misaligned,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                         input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [63:0]        r;
    b = v[7:0];
    h = v[15:0];
    w = v[31:0];
    r = v;
    unique case (sz)
      SZ_B:    if (uns) r = 64'(v[7:0]);  else r = 64'(b);
      SZ_H:    if (uns) r = 64'(v[15:0]); else r = 64'(h);
      SZ_W:    if (uns) r = 64'(v[31:0]); else r = 64'(w);
      default: r = v;
    endcase
    return r;
  endfunction

  logic [7:0]  byte_en;
  logic [7:0]  byte_en_sh;
  logic [63:0] bit_mask;

  always_comb begin
    unique case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = lane[0];
      SZ_W:    misaligned = |lane[1:0];
      default: misaligned = |lane;
    endcase
  end

  assign load_data = extend(rdata >> {lane, 3'b000}, size, is_unsigned);

  // Byte enables only make sense for aligned accesses, so the shift never wraps.
  always_comb begin
    unique case (size)
      SZ_B:    byte_en = 8'h01;
      SZ_H:    byte_en = 8'h03;
      SZ_W:    byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
    byte_en_sh = byte_en << lane;
    bit_mask   = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_en_sh[i]}};
    end
  end

  assign merged = (rdata & ~bit_mask) | ((wdata << {lane, 3'b000}) & bit_mask);

endmodule

// File: rtl/dmem_ctrl.sv
// Round-robin arbiter and access sequencer for the single-port 64-bit data memory.
// Define DMEM_CTRL_DEBUG_PORT_EN to enable the debug/loader port; otherwise it is inert.
import dmem_pkg::*;

module dmem_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  c_req_valid,
  output logic                  c_req_ready,
  input  logic                  c_req_we,
  input  logic [ADDR_WIDTH+2:0] c_req_addr,
  input  logic [1:0]            c_req_size,
  input  logic                  c_req_unsigned,
  input  logic [DATA_WIDTH-1:0] c_req_wdata,
  output logic                  c_rsp_valid,
  output logic [DATA_WIDTH-1:0] c_rsp_rdata,
  output logic                  c_rsp_err,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

`ifdef DMEM_CTRL_DEBUG_PORT_EN
  localparam logic DBG_EN = 1'b1;
`else
  localparam logic DBG_EN = 1'b0;
`endif

  state_t                  state;
  port_t                   port_q;
  port_t                   last_grant;
  logic [ADDR_WIDTH+2:0]   addr_q;
  logic [1:0]              size_q;
  logic                    we_q;
  logic                    uns_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   merged_q;
  logic                    c_rsp_valid_q, c_rsp_err_q, d_rsp_valid_q;
  logic [DATA_WIDTH-1:0]   c_rsp_rdata_q, d_rsp_rdata_q;

  logic                    idle, dbg_valid, grant_core, grant_dbg;
  logic                    misaligned, dw_store, in_access;
  logic [DATA_WIDTH-1:0]   load_data, merged;

  assign idle      = (state == IDLE);
  assign dbg_valid = d_req_valid & DBG_EN;

  // The port that was not granted last wins a tie.
  assign grant_core = idle && c_req_valid && !(dbg_valid && last_grant == PORT_CORE);
  assign grant_dbg  = idle && dbg_valid && !grant_core;

  assign c_req_ready = reset_n && idle && !(dbg_valid && last_grant == PORT_CORE);
  assign d_req_ready = DBG_EN && reset_n && idle && !(c_req_valid && last_grant == PORT_DBG);

  dmem_lane_unit u_lane (
    .lane        (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (mem_read_data),
    .misaligned  (misaligned),
    .load_data   (load_data),
    .merged      (merged)
  );

  // Request capture; debug accesses are normalised to an aligned doubleword.
  always_ff @(posedge clk) begin
    if (grant_core) begin
      addr_q  <= c_req_addr;
      size_q  <= c_req_size;
      we_q    <= c_req_we;
      uns_q   <= c_req_unsigned;
      wdata_q <= c_req_wdata;
    end else if (grant_dbg) begin
      addr_q  <= {d_req_addr, 3'b000};
      size_q  <= SZ_D;
      we_q    <= d_req_we;
      uns_q   <= 1'b1;
      wdata_q <= d_req_wdata;
    end
    if (state == ACCESS) merged_q <= merged;
  end

  assign dw_store  = we_q && (size_q == SZ_D);
  assign in_access = (state == ACCESS);

  assign mem_read       = in_access && !misaligned && !dw_store;
  assign mem_write      = (in_access && !misaligned && dw_store) || (state == WRITE);
  assign mem_addr       = (in_access || state == WRITE) ? addr_q[ADDR_WIDTH+2:3] : '0;
  assign mem_write_data = (state == WRITE) ? merged_q : (mem_write ? wdata_q : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      port_q        <= PORT_CORE;
      last_grant    <= PORT_DBG;
      c_rsp_valid_q <= 1'b0;
      c_rsp_err_q   <= 1'b0;
      c_rsp_rdata_q <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_rdata_q <= '0;
    end else begin
      c_rsp_valid_q <= 1'b0;
      c_rsp_err_q   <= 1'b0;
      c_rsp_rdata_q <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_rdata_q <= '0;
      unique case (state)
        IDLE: begin
          if (grant_core) begin
            port_q     <= PORT_CORE;
            last_grant <= PORT_CORE;
            state      <= ACCESS;
          end else if (grant_dbg) begin
            port_q     <= PORT_DBG;
            last_grant <= PORT_DBG;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (misaligned || dw_store || !we_q) begin
            state <= RESP;
            if (port_q == PORT_CORE) begin
              c_rsp_valid_q <= 1'b1;
              c_rsp_err_q   <= misaligned;
              c_rsp_rdata_q <= (misaligned || we_q) ? '0 : load_data;
            end else begin
              d_rsp_valid_q <= 1'b1;
              d_rsp_rdata_q <= we_q ? '0 : load_data;
            end
          end else begin
            state <= WRITE;
          end
        end
        WRITE: begin
          state <= RESP;
          if (port_q == PORT_CORE) c_rsp_valid_q <= 1'b1;
          else                     d_rsp_valid_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign c_rsp_valid = c_rsp_valid_q;
  assign c_rsp_err   = c_rsp_err_q;
  assign c_rsp_rdata = c_rsp_rdata_q;
  assign d_rsp_valid = d_rsp_valid_q & DBG_EN;
  assign d_rsp_rdata = DBG_EN ? d_rsp_rdata_q : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a per-cycle transaction model predicts memory strobes,
// readies and responses, and directed vectors pin the model with hand-computed values.
module tb_dmem_ctrl;

`ifdef DMEM_CTRL_DEBUG_PORT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c_req_valid, c_req_ready, c_req_we, c_req_unsigned;
  logic [12:0] c_req_addr;
  logic [1:0]  c_req_size;
  logic [63:0] c_req_wdata;
  logic        c_rsp_valid, c_rsp_err;
  logic [63:0] c_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [9:0]  d_req_addr;
  logic [63:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_rdata;
  logic [9:0]  mem_addr;
  logic [63:0] mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_size(c_req_size), .c_req_unsigned(c_req_unsigned),
    .c_req_wdata(c_req_wdata), .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
    .c_rsp_err(c_rsp_err), .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_we(d_req_we), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  // Memory attached to the controller.
  logic [63:0] tb_mem [0:1023];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr] <= mem_write_data;
  assign mem_read_data = tb_mem[mem_addr];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    bit          mr, mw;
    logic [9:0]  ma;
    logic [63:0] mwd;
    bit          cv, cerr;
    logic [63:0] crd;
    bit          dv;
    logic [63:0] drd;
  } exp_t;

  exp_t        exp_q [int];
  int          pend_a [int];
  logic [63:0] pend_d [int];
  logic [63:0] ref_mem [0:1023];
  int          idle_at = 0;
  bit          last_dbg = 1'b1;

  function automatic exp_t get_e(input int k);
    exp_t e;
    e = '{default: 0};
    if (exp_q.exists(k)) e = exp_q[k];
    return e;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] w, input int lane,
                                             input int nb, input bit uns);
    logic [63:0] v, m;
    v = w >> (8 * lane);
    m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic void schedule(input int cur, input bit is_dbg, input bit we,
                                   input logic [12:0] a, input int s, input bit uns,
                                   input logic [63:0] wd);
    int          ai, lane, nb, w, rc;
    bit          mis;
    logic [63:0] rd, m;
    exp_t        e;
    ai = int'(a); lane = ai % 8; nb = 1 << s; w = ai / 8;
    mis = (ai % nb) != 0;
    rd = '0;
    if (mis) begin
      rc = cur + 2;
    end else if (we && s == 3) begin
      e = get_e(cur + 1); e.mw = 1; e.ma = 10'(w); e.mwd = wd; exp_q[cur + 1] = e;
      pend_a[cur + 1] = w; pend_d[cur + 1] = wd;
      rc = cur + 2;
    end else if (!we) begin
      e = get_e(cur + 1); e.mr = 1; e.ma = 10'(w); exp_q[cur + 1] = e;
      rd = model_load(ref_mem[w], lane, nb, uns);
      rc = cur + 2;
    end else begin
      e = get_e(cur + 1); e.mr = 1; e.ma = 10'(w); exp_q[cur + 1] = e;
      m = ref_mem[w];
      for (int b = 0; b < nb; b++) m[8*(lane+b) +: 8] = wd[8*b +: 8];
      e = get_e(cur + 2); e.mw = 1; e.ma = 10'(w); e.mwd = m; exp_q[cur + 2] = e;
      pend_a[cur + 2] = w; pend_d[cur + 2] = m;
      rc = cur + 3;
    end
    e = get_e(rc);
    if (is_dbg) begin e.dv = 1; e.drd = rd; end
    else begin e.cv = 1; e.cerr = mis; e.crd = rd; end
    exp_q[rc] = e;
    idle_at = rc + 1;
  endfunction

  always @(posedge clk) begin
    int cur;
    bit idle, dv, cw, dw;
    cur = cyc;
    if (!reset_n) begin
      exp_q.delete(); pend_a.delete(); pend_d.delete();
      idle_at = cur + 1;
      last_dbg = 1'b1;
    end else begin
      if (pend_a.exists(cur)) ref_mem[pend_a[cur]] = pend_d[cur];
      idle = cur >= idle_at;
      dv = EN && d_req_valid;
      cw = idle && c_req_valid && !(dv && !last_dbg);
      dw = idle && dv && !cw;
      if (cw) begin
        last_dbg = 1'b0;
        schedule(cur, 1'b0, c_req_we, c_req_addr, int'(c_req_size), c_req_unsigned, c_req_wdata);
      end else if (dw) begin
        last_dbg = 1'b1;
        schedule(cur, 1'b1, d_req_we, {d_req_addr, 3'b000}, 3, 1'b0, d_req_wdata);
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    exp_t e;
    bit idle, dv, exp_cr, exp_dr;
    if (!reset_n) begin
      chk("reset_ctrl_outputs", {57'd0, c_req_ready, d_req_ready, c_rsp_valid, c_rsp_err,
                                 d_rsp_valid, mem_write, mem_read}, 64'd0);
      chk("reset_data_outputs", c_rsp_rdata | d_rsp_rdata | mem_write_data | {54'd0, mem_addr},
          64'd0);
    end else begin
      e = get_e(cyc);
      idle = cyc >= idle_at;
      dv = EN && d_req_valid;
      exp_cr = idle && !(dv && !last_dbg);
      exp_dr = EN && idle && !(c_req_valid && last_dbg);
      chk("c_req_ready", c_req_ready, exp_cr);
      chk("d_req_ready", d_req_ready, exp_dr);
      chk("mem_read", mem_read, e.mr);
      chk("mem_write", mem_write, e.mw);
      if (e.mr || e.mw) chk("mem_addr", mem_addr, e.ma);
      if (e.mw) chk("mem_write_data", mem_write_data, e.mwd);
      chk("c_rsp_valid", c_rsp_valid, e.cv);
      chk("c_rsp_err", c_rsp_err, e.cerr);
      chk("c_rsp_rdata", c_rsp_rdata, e.crd);
      chk("d_rsp_valid", d_rsp_valid, e.dv);
      chk("d_rsp_rdata", d_rsp_rdata, e.drd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_op(input bit we, input logic [12:0] a, input logic [1:0] s,
                         input bit uns, input logic [63:0] wd,
                         output logic [63:0] rd, output bit err, output int lat);
    int n;
    bit got;
    rd = '0; err = 1'b0; lat = -1; n = -1; got = 1'b0;
    c_req_valid = 1'b1; c_req_we = we; c_req_addr = a; c_req_size = s;
    c_req_unsigned = uns; c_req_wdata = wd;
    for (int i = 0; i < 20 && n < 0; i++) begin
      @(negedge clk);
      if (c_req_ready) n = cyc;
      tick();
    end
    chk("core_grant_seen", {63'd0, n >= 0}, 64'd1);
    // Inputs after the grant cycle must be ignored.
    c_req_valid = 1'b0; c_req_we = ~we; c_req_addr = ~a; c_req_size = ~s;
    c_req_unsigned = ~uns; c_req_wdata = ~wd;
    for (int i = 0; i < 8 && !got && n >= 0; i++) begin
      @(negedge clk);
      if (c_rsp_valid) begin
        got = 1'b1; rd = c_rsp_rdata; err = c_rsp_err; lat = cyc - n;
      end
    end
    chk("core_rsp_seen", {63'd0, got}, 64'd1);
    tick();
  endtask

  logic [63:0] rd;
  bit          err;
  int          lat;
  int          order [4];
  int          k;
  bit          seen;

  initial begin
    reset_n = 1'b0;
    c_req_valid = 0; c_req_we = 0; c_req_addr = '0; c_req_size = '0;
    c_req_unsigned = 0; c_req_wdata = '0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0;
    for (int i = 0; i < 1024; i++) begin tb_mem[i] = '0; ref_mem[i] = '0; end
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", c_req_ready, 64'd1);
    tick();

    core_op(1, 13'h040, 2'd3, 0, 64'h1122334455667788, rd, err, lat);
    chk("dw_store_latency", lat, 64'd2);
    chk("dw_store_rdata", rd, 64'd0);
    chk("dw_store_memword", tb_mem[8], 64'h1122334455667788);
    core_op(0, 13'h040, 2'd3, 0, 64'd0, rd, err, lat);
    chk("dw_load_latency", lat, 64'd2);
    chk("dw_load_rdata", rd, 64'h1122334455667788);
    chk("dw_load_err", err, 64'd0);

    core_op(1, 13'h043, 2'd0, 0, 64'h00000000000000AB, rd, err, lat);
    chk("byte_store_latency", lat, 64'd3);
    chk("byte_store_memword", tb_mem[8], 64'h11223344AB667788);

    core_op(1, 13'h040, 2'd3, 0, 64'h8000000000000000, rd, err, lat);
    core_op(0, 13'h046, 2'd1, 0, 64'd0, rd, err, lat);
    chk("half_load_signed", rd, 64'hFFFFFFFFFFFF8000);
    core_op(0, 13'h046, 2'd1, 1, 64'd0, rd, err, lat);
    chk("half_load_unsigned", rd, 64'h0000000000008000);

    core_op(0, 13'h042, 2'd2, 0, 64'd0, rd, err, lat);
    chk("misaligned_err", err, 64'd1);
    chk("misaligned_rdata", rd, 64'd0);
    chk("misaligned_latency", lat, 64'd2);

    // Reset while a byte store is in its WRITE cycle.
    core_op(1, 13'h080, 2'd3, 0, 64'h1122334455667788, rd, err, lat);
    c_req_valid = 1; c_req_we = 1; c_req_addr = 13'h081; c_req_size = 2'd0;
    c_req_unsigned = 0; c_req_wdata = 64'hCD;
    @(negedge clk);
    chk("rmw_grant_ready", c_req_ready, 64'd1);
    tick();
    c_req_valid = 0;
    tick();
    chk("mem_write_in_write", mem_write, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mem_write_drops", mem_write, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (c_rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_reset", seen, 64'd0);
    chk("rmw_word_unchanged", tb_mem[16], 64'h1122334455667788);
    tick();
    core_op(0, 13'h080, 2'd3, 0, 64'd0, rd, err, lat);
    chk("post_reset_load", rd, 64'h1122334455667788);
    chk("post_reset_latency", lat, 64'd2);

    // Arbitration: both ports held valid for four grants, starting from reset.
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    c_req_valid = 1; c_req_we = 0; c_req_addr = 13'h0A0; c_req_size = 2'd3; c_req_unsigned = 0;
    d_req_valid = 1; d_req_we = 1; d_req_addr = 10'd20; d_req_wdata = 64'hDEADBEEF0BADF00D;
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      @(negedge clk);
      if (c_req_valid && c_req_ready) begin order[k] = 0; k++; end
      else if (d_req_valid && d_req_ready) begin order[k] = 1; k++; end
      tick();
    end
    c_req_valid = 0;
    d_req_valid = 0;
    chk("grant_count", k, 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < k) chk($sformatf("grant_order_%0d", i), order[i], (EN && (i % 2 == 1)) ? 64'd1 : 64'd0);
    end
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
